// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I control FSM
// Sequences fetch/decode/execute/memory/writeback and drives all datapath enables and selects.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic       halt,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JAL      = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd15
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            wait_st, timeout, taken, br_bad, r_bad, i_bad;

  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  assign br_bad  = (funct3[2:1] == 2'b01);
  assign r_bad   = !((funct7 == 7'h00) || (funct7 == 7'h20)) ||
                   (funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101));
  assign i_bad   = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                   ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
  assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign timeout = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (wait_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        // Load/store direction is captured here so MEM_ADDR never reads the opcode.
        is_store_d = opcode[5];
        case (opcode)
          7'b0110011:             state_d = EXEC_R;
          7'b0010011:             state_d = EXEC_I;
          7'b0000011, 7'b0100011: state_d = MEM_ADDR;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          7'b0110111:             state_d = LUI;
          default:                state_d = TRAP;
        endcase
      end
      EXEC_R:   state_d = r_bad ? TRAP : WB_ALU;
      EXEC_I:   state_d = i_bad ? TRAP : WB_ALU;
      WB_ALU:   state_d = FETCH;
      MEM_ADDR: state_d = is_store_q ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = WB_MEM;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      WB_MEM:   state_d = FETCH;
      BRANCH:   state_d = br_bad ? TRAP : FETCH;
      JAL:      state_d = FETCH;
      LUI:      state_d = FETCH;
      default:  state_d = TRAP;
    endcase
    if (timeout) state_d = TRAP;
  end

  // Wait counter restarts on every state change, so it only accumulates within one wait.
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) && wait_st && !mem_ready) wait_d = wait_q + 1'b1;
  end

  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = OP_ADD;
    halt      = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      EXEC_R:   alu_op = f3_op(funct3, funct7[5]);
      EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = f3_op(funct3, funct7[5] && (funct3 == 3'b101));
      end
      WB_ALU:   reg_write = 1'b1;
      MEM_ADDR: alu_src_b = 1'b1;
      MEM_RD:   mem_read = 1'b1;
      MEM_WR:   mem_write = 1'b1;
      WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
      end
      BRANCH: begin
        alu_op   = OP_SUB;
        pc_src   = 2'd1;
        pc_write = taken && !br_bad;
      end
      JAL: begin
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_write  = 1'b1;
        pc_src    = 2'd2;
      end
      LUI: begin
        reg_write = 1'b1;
        wb_sel    = 2'd3;
      end
      TRAP:     halt = 1'b1;
      default:  ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl
// Per-cycle stimulus and expected output vectors are queued, then replayed and compared.
module tb_mc_ctrl;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] LU = 7'b0110111;

  typedef struct packed {
    logic       mr;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       lt;
    logic       ltu;
  } stim_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] aop;
  } alu_case_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_b, halt;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] alu_op, state_o;
  logic       pc_write2, ir_write2, reg_write2, mem_read2, mem_write2, alu_src_b2, halt2;
  logic [1:0] pc_src2, wb_sel2;
  logic [3:0] alu_op2, state_o2;

  logic [18:0] obs, obs2;
  assign obs  = {state_o, pc_write, pc_src, ir_write, reg_write, wb_sel,
                 mem_read, mem_write, alu_src_b, alu_op, halt};
  assign obs2 = {state_o2, pc_write2, pc_src2, ir_write2, reg_write2, wb_sel2,
                 mem_read2, mem_write2, alu_src_b2, alu_op2, halt2};

  int total = 0;
  int bad = 0;
  stim_t       stim_q[$];
  logic [18:0] exp_q[$];
  logic [18:0] exp2_q[$];
  logic [18:0] e_idle, e_fok, e_fwait, e_dec, e_wba, e_trap;

  mc_ctrl #(.MEM_TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .mem_read(mem_read), .mem_write(mem_write), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .halt(halt), .state_o(state_o)
  );

  mc_ctrl #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write2), .pc_src(pc_src2), .ir_write(ir_write2), .reg_write(reg_write2),
    .wb_sel(wb_sel2), .mem_read(mem_read2), .mem_write(mem_write2), .alu_src_b(alu_src_b2),
    .alu_op(alu_op2), .halt(halt2), .state_o(state_o2)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ev(input logic [3:0] st, input logic pcw, input logic [1:0] pcs,
                                     input logic irw, input logic rw, input logic [1:0] wbs,
                                     input logic mrd, input logic mwr, input logic asb,
                                     input logic [3:0] aop, input logic h);
    return {st, pcw, pcs, irw, rw, wbs, mrd, mwr, asb, aop, h};
  endfunction

  function automatic stim_t st(input logic mr, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input logic lt, input logic ltu);
    return {mr, op, f3, f7, z, lt, ltu};
  endfunction

  function automatic void push(input stim_t s, input logic [18:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== 19'd0 || obs2 !== 19'd0) begin
      bad++;
      $display("FAIL reset: got %h/%h want 0", obs, obs2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    alu_case_t cases[10] = '{
      '{R, 3'd0, 7'h00, 4'd0}, '{R, 3'd0, 7'h20, 4'd1}, '{R, 3'd5, 7'h20, 4'd7},
      '{R, 3'd5, 7'h00, 4'd6}, '{R, 3'd2, 7'h00, 4'd3}, '{I, 3'd5, 7'h20, 4'd7},
      '{I, 3'd0, 7'h20, 4'd0}, '{I, 3'd7, 7'h55, 4'd9}, '{I, 3'd3, 7'h7f, 4'd4},
      '{I, 3'd1, 7'h00, 4'd2}};
    stim_t s;
    logic [18:0] e;
    int n = 0;
    test_reset();
    push(st(1, R, 0, 0, 0, 0, 0), e_idle);
    foreach (cases[i]) begin
      s = st(1, cases[i].op, cases[i].f3, cases[i].f7, 0, 0, 0);
      push(s, e_fok);
      push(s, e_dec);
      push(s, ev((cases[i].op == I) ? 4'd4 : 4'd3, 0, 0, 0, 0, 0, 0, 0,
                 cases[i].op == I, cases[i].aop, 0));
      push(s, e_wba);
    end
    push(st(1, R, 0, 0, 0, 0, 0), e_fok);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {mem_ready, opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu} = s;
      #2; total++;
      if (obs !== e) begin bad++; $display("FAIL alu[%0d]: got %h want %h", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_load_store();
    stim_t s;
    logic [18:0] e;
    int n = 0;
    test_reset();
    push(st(1, LD, 2, 0, 0, 0, 0), e_idle);
    push(st(1, LD, 2, 0, 0, 0, 0), e_fok);
    push(st(0, LD, 2, 0, 0, 0, 0), e_dec);
    push(st(1, LD, 2, 0, 0, 0, 0), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) push(st(0, LD, 2, 0, 0, 0, 0), ev(6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push(st(1, LD, 2, 0, 0, 0, 0), ev(6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push(st(0, LD, 2, 0, 0, 0, 0), ev(9, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    push(st(0, SW, 2, 0, 0, 0, 0), e_fwait);
    push(st(1, SW, 2, 0, 0, 0, 0), e_fok);
    push(st(1, SW, 2, 0, 0, 0, 0), e_dec);
    push(st(1, LD, 2, 0, 0, 0, 0), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    push(st(0, SW, 2, 0, 0, 0, 0), ev(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(st(1, SW, 2, 0, 0, 0, 0), ev(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(st(1, SW, 2, 0, 0, 0, 0), e_fok);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {mem_ready, opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu} = s;
      #2; total++;
      if (obs !== e) begin bad++; $display("FAIL ldst[%0d]: got %h want %h", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_branch_jal_lui();
    logic [6:0] br_tab[6] = '{7'b000_100_1, 7'b001_100_0, 7'b111_000_1,
                              7'b100_001_0, 7'b101_000_1, 7'b110_001_1};
    logic [6:0] b;
    stim_t s;
    logic [18:0] e;
    int n = 0;
    test_reset();
    push(st(1, 7'h7f, 0, 0, 0, 0, 0), e_idle);
    for (int i = 0; i < 6; i++) begin
      b = br_tab[i];
      push(st(1, 7'h7f, b[6:4], 0, 0, 0, 0), e_fok);
      push(st(1, BR, b[6:4], 0, 0, 0, 0), e_dec);
      push(st(1, 7'h7f, b[6:4], 0, b[3], b[2], b[1]), ev(10, b[0], 1, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    push(st(1, JL, 0, 0, 0, 0, 0), e_fok);
    push(st(1, JL, 0, 0, 0, 0, 0), e_dec);
    push(st(1, JL, 0, 0, 0, 0, 0), ev(11, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0));
    push(st(1, LU, 0, 0, 0, 0, 0), e_fok);
    push(st(1, LU, 0, 0, 0, 0, 0), e_dec);
    push(st(1, LU, 0, 0, 0, 0, 0), ev(12, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    push(st(1, LU, 0, 0, 0, 0, 0), e_fok);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {mem_ready, opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu} = s;
      #2; total++;
      if (obs !== e) begin bad++; $display("FAIL br_j[%0d]: got %h want %h", n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic has_mid, input logic [18:0] mid);
    stim_t s;
    logic [18:0] e;
    int n = 0;
    test_reset();
    push(st(1, op, f3, f7, 0, 0, 0), e_idle);
    push(st(1, op, f3, f7, 0, 0, 0), e_fok);
    push(st(1, op, f3, f7, 0, 0, 0), e_dec);
    if (has_mid) push(st(1, op, f3, f7, 1, 1, 1), mid);
    for (int k = 0; k < 21; k++)
      push(st(1'($urandom()), 7'($urandom()), 3'($urandom()), 7'($urandom()), 0, 0, 0), e_trap);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      {mem_ready, opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu} = s;
      #2; total++;
      if (obs !== e) begin bad++; $display("FAIL %s[%0d]: got %h want %h", tag, n, obs, e); end
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t s;
    logic [18:0] e;
    int n = 0;
    test_reset();
    push(st(1, SW, 2, 0, 0, 0, 0), e_idle);
    push(st(1, SW, 2, 0, 0, 0, 0), e_fok);
    push(st(1, SW, 2, 0, 0, 0, 0), e_dec);
    push(st(1, SW, 2, 0, 0, 0, 0), ev(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    push(st(0, SW, 2, 0, 0, 0, 0), ev(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(st(0, SW, 2, 0, 0, 0, 0), ev(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int phase = 0; phase < 2; phase++) begin
      while (exp_q.size() > 0) begin
        s = stim_q.pop_front();
        e = exp_q.pop_front();
        {mem_ready, opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu} = s;
        #2; total++;
        if (obs !== e) begin bad++; $display("FAIL rstwr[%0d]: got %h want %h", n, obs, e); end
        @(posedge clk); #1; n++;
      end
      if (phase == 0) begin
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1; total++;
        if (obs !== 19'd0) begin bad++; $display("FAIL rst_async: got %h want 0", obs); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(st(1, SW, 2, 0, 0, 0, 0), e_idle);
        push(st(1, SW, 2, 0, 0, 0, 0), e_fok);
      end
    end
  endtask

  task automatic test_timeout();
    logic [18:0] e, e2;
    int n = 0;
    test_reset();
    exp_q.push_back(e_idle);
    exp2_q.push_back(e_idle);
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(e_fwait);
      exp2_q.push_back((k < 4) ? e_fwait : e_trap);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e2 = exp2_q.pop_front();
      mem_ready = 1'b0;
      #2; total += 2;
      if (obs !== e) begin bad++; $display("FAIL no_to[%0d]: got %h want %h", n, obs, e); end
      if (obs2 !== e2) begin bad++; $display("FAIL to4[%0d]: got %h want %h", n, obs2, e2); end
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    e_idle  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_fok   = ev(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    e_fwait = ev(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    e_dec   = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_wba   = ev(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_trap  = ev(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jal_lui();
    test_illegal("ill_op", 7'h7f, 3'd0, 7'h00, 1'b0, e_dec);
    test_illegal("ill_f7", R, 3'd0, 7'h01, 1'b1, ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_illegal("ill_br", BR, 3'd2, 7'h00, 1'b1, ev(10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    test_reset_mid_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the RV32I core. It sequences the fetch/decode datapath (IR latch, register-field/immediate decode, ALU, memory port, PC update) one instruction at a time. It consumes the decoded `opcode`/`funct3`/`funct7` fields and ALU flags, and drives every datapath enable and mux select. Memory accesses use a ready handshake so the FSM stalls on slow memory.

## Interface
- `MEM_TIMEOUT`, 0: if non-zero, the max cycles to wait for `mem_ready` before entering TRAP; 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  7  decoded opcode, valid from the DECODE state onward.
- `funct3`  in  3  decoded funct3.
- `funct7`  in  7  decoded funct7.
- `alu_zero`, `alu_lt`, `alu_ltu`  in  1 each  ALU compare flags (rs1−rs2 result, signed/unsigned less-than).
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`  out  1  load PC this cycle.
- `pc_src`  out  2  0 = PC+4, 1 = branch target, 2 = JAL target.
- `ir_write`  out  1  latch instruction and old PC.
- `reg_write`  out  1  register-file write enable (rd).
- `wb_sel`  out  2  0 = ALU, 1 = memory data, 2 = PC (already incremented), 3 = imm32.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `alu_src_b`  out  1  0 = rs2, 1 = imm32.
- `alu_op`  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- `halt`  out  1  sticky; set in TRAP.
- `state_o`  out  4  current state encoding, for debug.

## Operation
- States and encodings:
  - IDLE = 0
  - FETCH = 1
  - DECODE = 2
  - EXEC_R = 3
  - EXEC_I = 4
  - MEM_ADDR = 5
  - MEM_RD = 6
  - MEM_WR = 7
  - WB_ALU = 8
  - WB_MEM = 9
  - BRANCH = 10
  - JAL = 11
  - LUI = 12
  - TRAP = 15
- Outputs are Moore: decoded from the state register, except the FETCH/MEM handshake terms and `pc_write` in BRANCH.
- **IDLE:** all outputs 0; → FETCH unconditionally.
- **FETCH:** `mem_read` = 1. While `mem_ready` = 0, hold in FETCH. When `mem_ready` = 1: `ir_write` = 1, `pc_write` = 1, `pc_src` = 0, → DECODE.
- **DECODE:** no strobes. Dispatch on `opcode`:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → TRAP
- **EXEC_R:** `alu_src_b` = 0. `alu_op` comes from `funct3`, with `funct7[5]` selecting SUB (funct3 000) or SRA (funct3 101). `funct7` other than 0000000/0100000, or `funct7[5]` set with funct3 ∉ {000, 101} → TRAP. Otherwise → WB_ALU.
- **EXEC_I:** `alu_src_b` = 1. funct3 000 is always ADD. `funct7[5]` is honoured only for funct3 101 (SRAI). Bad `funct7` on funct3 001/101 → TRAP. Otherwise → WB_ALU.
- **WB_ALU:** `reg_write` = 1, `wb_sel` = 0; → FETCH.
- **MEM_ADDR:** `alu_src_b` = 1, ADD. Load → MEM_RD; store → MEM_WR.
- **MEM_RD:** `mem_read` = 1; wait for `mem_ready`; → WB_MEM.
- **MEM_WR:** `mem_write` = 1; wait for `mem_ready`; → FETCH.
- **WB_MEM:** `reg_write` = 1, `wb_sel` = 1; → FETCH.
- **BRANCH:** `alu_op` = SUB.
  - taken = beq: zero; bne: !zero; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu.
  - `pc_write` = taken, `pc_src` = 1; → FETCH.
  - funct3 010/011 → TRAP, with no PC write.
- **JAL:** `reg_write` = 1, `wb_sel` = 2, `pc_write` = 1, `pc_src` = 2; → FETCH.
- **LUI:** `reg_write` = 1, `wb_sel` = 3; → FETCH.
- **TRAP:** `halt` = 1, all other outputs 0; absorbing until reset.
- **Timeout** (`MEM_TIMEOUT` > 0): a wait counter clears on entry to FETCH/MEM_RD/MEM_WR. It → TRAP when the count reaches `MEM_TIMEOUT` with `mem_ready` still 0.

## Timing
- Reset (`rst_n` = 0, any state, including mid-wait): state = IDLE, wait counter = 0, all outputs 0 asynchronously.
- Cycles per instruction, with zero-wait memory (`mem_ready` high on the first strobe cycle):
  - R/I-ALU: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - LUI: 3
- Each memory wait cycle adds 1.
- Strobes hold stable while waiting. `ir_write`/`pc_write` pulse exactly one cycle, in the `mem_ready` cycle.
- Decode fields are sampled only in DECODE/EXEC/BRANCH. The datapath holds them from the IR, so changes on these inputs in other states are ignored.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.

## Test plan
- Reset then `mem_ready` tied 1, IR = add (opcode 0110011, funct7 0) → states 0,1,2,3,8,1; `reg_write` = 1 exactly in WB_ALU; `alu_op` = 0.
- Load (0000011) with `mem_ready` delayed 3 cycles in MEM_RD → `mem_read` held 4 cycles; WB_MEM follows with `wb_sel` = 1; total 8 cycles from FETCH.
- Branch sweep: beq with `alu_zero` = 1 → `pc_write` = 1, `pc_src` = 1. bne with `alu_zero` = 1 → `pc_write` = 0. bgeu with `alu_ltu` = 0 → taken.
- Illegal cases → `halt` = 1 and `state_o` = 15, held 20 further cycles:
  - opcode 1111111
  - R-type with `funct7` = 0000001
  - funct3 010 on branch
- `rst_n` low during MEM_WR wait → outputs 0 immediately; after release, IDLE then FETCH.
- `MEM_TIMEOUT` = 4, `mem_ready` stuck 0 in FETCH → TRAP after 4 wait cycles.
